// File: rtl/mmio_bus_ctl.sv
// LC-3 memory / memory-mapped IO access controller with wait-stated memory and device-slot strobes.
// Optional error logging (err_addr, err_cnt) is built when MMIO_ERR_LOG_EN is defined.
module mmio_bus_ctl #(
  parameter int unsigned        ADDR_W  = 16,
  parameter int unsigned        DATA_W  = 16,
  parameter logic [ADDR_W-1:0]  IO_BASE = 16'h7E00,
  parameter int unsigned        NUM_DEV = 24,
  parameter logic [31:0]        RD_MASK = 32'h00FF_FFFF,
  parameter logic [31:0]        WR_MASK = 32'h00FF_FFFF,
  parameter int unsigned        MEM_LAT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         MAR,
  input  logic [DATA_W-1:0]         MDR_in,
  input  logic                      R_W,
  input  logic                      MIO_EN,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
  output logic                      R,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [NUM_DEV-1:0]        dev_ld,
  output logic [NUM_DEV-1:0]        dev_rd,
  output logic [DATA_W-1:0]         dev_wdata,
  output logic                      bus_err
`ifdef MMIO_ERR_LOG_EN
  ,
  output logic [ADDR_W-1:0]         err_addr,
  output logic [7:0]                err_cnt
`endif
);

  localparam int unsigned SLOT_W = 5;
  localparam int unsigned CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  // state   | meaning
  // IDLE    | waiting for MIO_EN; request fields latched on the accepting edge
  // MEM_ACC | mem_en held while the wait-state counter runs down
  // IO_ACC  | single cycle with the device strobe asserted
  // DONE    | R (and bus_err) high; MIO_EN ignored
  typedef enum logic [1:0] {IDLE, MEM_ACC, IO_ACC, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic                err_q, err_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   dev_wdata_q, dev_wdata_d;
  logic [NUM_DEV-1:0]  dev_ld_q, dev_ld_d;
  logic [NUM_DEV-1:0]  dev_rd_q, dev_rd_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                r_q, r_d;
  logic                bus_err_q, bus_err_d;
`ifdef MMIO_ERR_LOG_EN
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
`endif

  logic [ADDR_W-1:0]   off;
  logic                in_io;
  logic [SLOT_W-1:0]   req_slot;
  logic                req_mapped;
  logic [DATA_W-1:0]   rd_sel;

  // Unsigned wrap of the subtract pushes addresses below IO_BASE far above NUM_DEV.
  assign off        = MAR - IO_BASE;
  assign in_io      = (off < ADDR_W'(NUM_DEV));
  assign req_slot   = off[SLOT_W-1:0];
  assign req_mapped = R_W ? WR_MASK[req_slot] : RD_MASK[req_slot];

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (slot_q == SLOT_W'(i)) rd_sel = dev_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    err_d       = err_q;
    slot_d      = slot_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dev_wdata_d = dev_wdata_q;
    dev_ld_d    = '0;
    dev_rd_d    = '0;
    rdata_d     = rdata_q;
    r_d         = 1'b0;
    bus_err_d   = 1'b0;
`ifdef MMIO_ERR_LOG_EN
    err_addr_d  = err_addr_q;
    err_cnt_d   = err_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (MIO_EN) begin
          mem_addr_d  = MAR;
          mem_wdata_d = MDR_in;
          dev_wdata_d = MDR_in;
          rw_d        = R_W;
          slot_d      = req_slot;
          if (in_io) begin
            state_d = IO_ACC;
            err_d   = ~req_mapped;
            for (int i = 0; i < NUM_DEV; i++) begin
              dev_ld_d[i] = req_mapped &  R_W & (req_slot == SLOT_W'(i));
              dev_rd_d[i] = req_mapped & ~R_W & (req_slot == SLOT_W'(i));
            end
          end else begin
            state_d  = MEM_ACC;
            err_d    = 1'b0;
            mem_en_d = 1'b1;
            mem_we_d = R_W;
            cnt_d    = CNT_LOAD;
          end
        end
      end
      MEM_ACC: begin
        if (cnt_q == '0) begin
          if (!rw_q) rdata_d = mem_rdata;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          r_d      = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      IO_ACC: begin
        if (!rw_q) rdata_d = err_q ? '0 : rd_sel;
        r_d       = 1'b1;
        bus_err_d = err_q;
        state_d   = DONE;
`ifdef MMIO_ERR_LOG_EN
        if (err_q) begin
          err_addr_d = mem_addr_q;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      err_q       <= 1'b0;
      slot_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dev_wdata_q <= '0;
      dev_ld_q    <= '0;
      dev_rd_q    <= '0;
      rdata_q     <= '0;
      r_q         <= 1'b0;
      bus_err_q   <= 1'b0;
`ifdef MMIO_ERR_LOG_EN
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      err_q       <= err_d;
      slot_q      <= slot_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dev_wdata_q <= dev_wdata_d;
      dev_ld_q    <= dev_ld_d;
      dev_rd_q    <= dev_rd_d;
      rdata_q     <= rdata_d;
      r_q         <= r_d;
      bus_err_q   <= bus_err_d;
`ifdef MMIO_ERR_LOG_EN
      err_addr_q  <= err_addr_d;
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign R         = r_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dev_ld    = dev_ld_q;
  assign dev_rd    = dev_rd_q;
  assign dev_wdata = dev_wdata_q;
  assign bus_err   = bus_err_q;
`ifdef MMIO_ERR_LOG_EN
  assign err_addr  = err_addr_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule
